// File: rtl/ram_pkg.sv
// Shared types and defaults for the data-memory responder.
// Used by ram_rsp (FSM/response) and ram_sp_array (storage).
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ram_rsp_state_e;

  localparam logic [31:0] RAM_BASE_ADDR_DEF = 32'h8000_0000;
  localparam int          RAM_DEPTH_DEF     = 4096;
  localparam int          RAM_CNT_W         = 4;

  // Response sideband latched at accept; rd_sel gates the array word onto the bus.
  typedef struct packed {
    logic rd_sel;
    logic err;
  } ram_rsp_meta_t;

endpackage

// File: rtl/ram_sp_array.sv
// Single-port synchronous word array: one edge returns the old word and writes the new one.
// Latency 1 cycle for read data; no backpressure, no reset on contents.
module ram_sp_array #(
  parameter int DEPTH      = 4096,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read and write share the edge; rd_data always sees the pre-write word.
  always_ff @(posedge clk) begin
    if (en) begin
      rd_data <= mem[idx];
      if (we) begin
        mem[idx] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/ram_rsp.sv
// LSU-facing RAM responder: one request at a time, read-before-write, response LATENCY cycles after accept.
// Response is held stable in RESP until i_rsp_ready; requests are refused outside IDLE.
module ram_rsp
  import ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = RAM_DEPTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(RAM_BASE_ADDR_DEF),
  parameter int                    LATENCY    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_rd_en,
  input  logic                  i_req_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wr_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rd_data,
  output logic                  o_rsp_err
);

  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   SPAN     = (ADDR_WIDTH+1)'(DEPTH) << 2;
  localparam logic [RAM_CNT_W-1:0]  CNT_LOAD = RAM_CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  ram_rsp_state_e        state;
  logic [RAM_CNT_W-1:0]  cnt;
  ram_rsp_meta_t         meta;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic                  accept;
  logic                  arr_en;
  logic                  arr_we;
  logic [DATA_WIDTH-1:0] arr_rd_data;

  // Wrap-around subtraction: addresses below the base become huge and fail the compare.
  assign offset   = i_req_addr - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);
  assign accept   = i_req_valid && (state == IDLE);
  assign arr_en   = accept && in_range && (i_req_rd_en || i_req_wr_en);
  assign arr_we   = accept && in_range && i_req_wr_en;

  ram_sp_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (i_clk),
    .en      (arr_en),
    .we      (arr_we),
    .idx     (offset[IDX_W+1:2]),
    .wr_data (i_req_wr_data),
    .rd_data (arr_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      meta  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            meta.rd_sel <= in_range && i_req_rd_en;
            meta.err    <= !in_range;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The array output register only moves on accept, so it doubles as the response data register.
  assign o_req_ready   = (state == IDLE);
  assign o_rsp_valid   = (state == RESP);
  assign o_rsp_rd_data = meta.rd_sel ? arr_rd_data : '0;
  assign o_rsp_err     = meta.err;

endmodule

// File: tb/tb_ram_rsp.sv
// Directed bench for ram_rsp: a LATENCY=2 instance for function/timing/reset, a LATENCY=1 instance for throughput.
module tb_ram_rsp;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, rd_en, wr_en, rsp_valid, rsp_ready, err;
  logic [31:0] addr, wdata, rdata;

  logic        r1_req_valid, r1_req_ready, r1_rd_en, r1_wr_en, r1_rsp_valid, r1_rsp_ready, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;

  int checks;
  int failures;

  ram_rsp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_rd_en(rd_en), .i_req_wr_en(wr_en),
    .i_req_addr(addr), .i_req_wr_data(wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rd_data(rdata), .o_rsp_err(err)
  );

  ram_rsp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(r1_req_valid), .o_req_ready(r1_req_ready),
    .i_req_rd_en(r1_rd_en), .i_req_wr_en(r1_wr_en),
    .i_req_addr(r1_addr), .i_req_wr_data(r1_wdata),
    .o_rsp_valid(r1_rsp_valid), .i_rsp_ready(r1_rsp_ready),
    .o_rsp_rd_data(r1_rdata), .o_rsp_err(r1_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Starts and ends just after a negedge; returns the response and the accept-to-valid cycle count.
  task automatic req(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                     output logic [31:0] d, output logic e, output int lat);
    req_valid = 1'b1; addr = a; rd_en = rd; wr_en = wr; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = rdata;
    e = err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] d;
  logic        e;
  int          lat;
  logic [31:0] v_a   [4];
  logic        v_rd  [4];
  logic        v_wr  [4];
  logic [31:0] v_wd  [4];
  logic [31:0] v_exp [4];

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; rst_n = 1'b0;
    req_valid = 0; rd_en = 0; wr_en = 0; addr = '0; wdata = '0; rsp_ready = 0;
    r1_req_valid = 0; r1_rd_en = 0; r1_wr_en = 0; r1_addr = '0; r1_wdata = '0; r1_rsp_ready = 1;

    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rdata, 32'd0);
    chk("rst_rsp_err", 32'(err), 32'd0);
    chk("rst_l1_req_ready", 32'(r1_req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read
    req(32'h8000_0010, 1'b0, 1'b1, 32'hDEAD_BEEF, d, e, lat);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_data", d, 32'd0);
    chk("wr_err", 32'(e), 32'd0);
    req(32'h8000_0010, 1'b1, 1'b0, 32'h0, d, e, lat);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_data", d, 32'hDEAD_BEEF);
    chk("rd_err", 32'(e), 32'd0);

    // Read-before-write
    req(32'h8000_0014, 1'b0, 1'b1, 32'h1111_1111, d, e, lat);
    req(32'h8000_0014, 1'b1, 1'b1, 32'h2222_2222, d, e, lat);
    chk("rbw_old", d, 32'h1111_1111);
    req(32'h8000_0014, 1'b1, 1'b0, 32'h0, d, e, lat);
    chk("rbw_new", d, 32'h2222_2222);

    // Range boundaries: base and top word in range, neighbours outside
    req(32'h8000_0000, 1'b0, 1'b1, 32'h1234_5678, d, e, lat);
    req(32'h8000_003C, 1'b0, 1'b1, 32'hCAFE_0001, d, e, lat);
    chk("top_err", 32'(e), 32'd0);
    req(32'h7FFF_FFFC, 1'b1, 1'b1, 32'hEEEE_EEEE, d, e, lat);
    chk("below_err", 32'(e), 32'd1);
    chk("below_data", d, 32'd0);
    req(32'h8000_0040, 1'b1, 1'b1, 32'hEEEE_EEEE, d, e, lat);
    chk("above_err", 32'(e), 32'd1);
    chk("above_data", d, 32'd0);
    chk("above_lat", 32'(lat), 32'd2);
    req(32'h8000_0000, 1'b1, 1'b0, 32'h0, d, e, lat);
    chk("base_unchanged", d, 32'h1234_5678);
    chk("base_err", 32'(e), 32'd0);
    req(32'h8000_003C, 1'b1, 1'b0, 32'h0, d, e, lat);
    chk("top_unchanged", d, 32'hCAFE_0001);

    // Fence: neither read nor write
    req(32'h8000_0010, 1'b0, 1'b0, 32'hFFFF_FFFF, d, e, lat);
    chk("noop_data", d, 32'd0);
    chk("noop_err", 32'(e), 32'd0);
    chk("noop_lat", 32'(lat), 32'd2);
    req(32'h8000_0020, 1'b0, 1'b1, 32'hAAAA_0000, d, e, lat);

    // Back-pressure with a competing request held on the input
    req_valid = 1'b1; addr = 32'h8000_0010; rd_en = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    addr = 32'h8000_0020; rd_en = 1'b0; wr_en = 1'b1; wdata = 32'hBBBB_BBBB;
    @(negedge clk);
    chk("bp_valid_first", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rdata, 32'hDEAD_BEEF);
      chk("bp_err", 32'(err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; wr_en = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_done_valid", 32'(rsp_valid), 32'd0);
    chk("bp_done_ready", 32'(req_ready), 32'd1);
    req(32'h8000_0020, 1'b1, 1'b0, 32'h0, d, e, lat);
    chk("bp_not_accepted", d, 32'hAAAA_0000);

    // Asynchronous reset while waiting on a write
    req_valid = 1'b1; addr = 32'h8000_0024; rd_en = 1'b0; wr_en = 1'b1; wdata = 32'h5A5A_5A5A;
    @(posedge clk);
    #2;
    chk("wait_req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0; wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req(32'h8000_0024, 1'b1, 1'b0, 32'h0, d, e, lat);
    chk("arst_write_kept", d, 32'h5A5A_5A5A);
    chk("arst_lat", 32'(lat), 32'd2);

    // LATENCY=1 instance: back-to-back requests with rsp_ready tied high
    v_a[0] = 32'h8000_0000; v_rd[0] = 1'b0; v_wr[0] = 1'b1; v_wd[0] = 32'h1111_0000; v_exp[0] = 32'h0;
    v_a[1] = 32'h8000_0004; v_rd[1] = 1'b0; v_wr[1] = 1'b1; v_wd[1] = 32'h2222_0004; v_exp[1] = 32'h0;
    v_a[2] = 32'h8000_0000; v_rd[2] = 1'b1; v_wr[2] = 1'b0; v_wd[2] = 32'h0;         v_exp[2] = 32'h1111_0000;
    v_a[3] = 32'h8000_0004; v_rd[3] = 1'b1; v_wr[3] = 1'b0; v_wd[3] = 32'h0;         v_exp[3] = 32'h2222_0004;
    for (int i = 0; i < 4; i++) begin
      r1_req_valid = 1'b1; r1_addr = v_a[i]; r1_rd_en = v_rd[i]; r1_wr_en = v_wr[i]; r1_wdata = v_wd[i];
      chk("l1_req_ready", 32'(r1_req_ready), 32'd1);
      @(negedge clk);
      chk("l1_rsp_valid", 32'(r1_rsp_valid), 32'd1);
      chk("l1_busy", 32'(r1_req_ready), 32'd0);
      chk("l1_data", r1_rdata, v_exp[i]);
      chk("l1_err", 32'(r1_err), 32'd0);
      @(negedge clk);
    end
    r1_req_valid = 1'b0; r1_rd_en = 1'b0; r1_wr_en = 1'b0;
    chk("l1_idle_valid", 32'(r1_rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_rsp.md
# ram_rsp

Data-memory responder for the L2 core: the RAM-side end of the LSU memory interface. Accepts one load/store request at a time over a valid/ready handshake, performs a read-before-write on a word-addressed SRAM array, and returns the pre-write word after a fixed wait-state latency. The LSU performs byte-lane extraction and read-modify-write merging, so this block handles whole 32-bit words only.

## Interface

Parameters:

- `DEPTH`, 4096: number of 32-bit words in the array; power of two, ≥ 2.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0; aligned to `DEPTH*4`.
- `LATENCY`, 2: cycles from request accept to `o_rsp_valid`; range 1..15.

Ports:

- `i_clk`, in, 1: clock. Single clock domain.
- `i_rst_n`, in, 1: reset. Asynchronous assert, active-low.
- `i_req_valid`, in, 1: request present.
- `o_req_ready`, out, 1: request can be accepted.
- `i_req_rd_en`, in, 1: return array word.
- `i_req_wr_en`, in, 1: write `i_req_wr_data`.
- `i_req_addr`, in, `ADDR_WIDTH`: byte address; bits [1:0] are ignored.
- `i_req_wr_data`, in, `DATA_WIDTH`: full merged word from the LSU.
- `o_rsp_valid`, out, 1: response present.
- `i_rsp_ready`, in, 1: consumer takes the response.
- `o_rsp_rd_data`, out, `DATA_WIDTH`: word as it was before any write in the same request.
- `o_rsp_err`, out, 1: address was out of range.

## Operation

- FSM states IDLE, WAIT, RESP. Reset state is IDLE.
- `o_req_ready` = (state == IDLE). `o_rsp_valid` = (state == RESP).
- A request is accepted on the rising edge where `i_req_valid && o_req_ready`.
  - In range is defined as `BASE_ADDR <= addr < BASE_ADDR + DEPTH*4`. Index = `(addr - BASE_ADDR) >> 2`, width `$clog2(DEPTH)`.
  - In range, the same edge does two things:
    - latches `mem[idx]` into the response register if `rd_en`, otherwise latches 0;
    - writes `mem[idx] <= wr_data` if `wr_en`.
  - The latched value is always the old word (read-before-write). This is required for the LSU read-modify-write.
  - Out of range: response data = 0 and `o_rsp_err` is latched to 1. The write is dropped and the array is unchanged.
  - `rd_en = wr_en = 0` is still accepted and returns data 0, err 0 (acts as a fence/no-op).
- Transition from IDLE on accept:
  - if `LATENCY == 1`, go to RESP;
  - otherwise load the wait counter with `LATENCY - 2` and go to WAIT.
- WAIT decrements the counter each cycle and moves to RESP when the counter is 0.
- RESP holds `o_rsp_valid`, `o_rsp_rd_data` and `o_rsp_err` stable until `i_rsp_ready`. The handshake edge returns the FSM to IDLE.
- Request inputs are ignored outside IDLE. No new request is accepted in the same cycle as a response handshake.
- The array has no reset. Its contents are undefined until written.

## Timing

- Accept at edge T gives `o_rsp_valid` = 1 from edge `T + LATENCY` onward.
- Minimum request period is `LATENCY + 1` cycles, with `i_rsp_ready` tied high.
- Reset values: `o_req_ready` = 1 (state IDLE), `o_rsp_valid` = 0, `o_rsp_rd_data` = 0, `o_rsp_err` = 0, counter = 0.
- Reset during WAIT or RESP: FSM returns to IDLE immediately (asynchronous) and the response is lost. A write already committed at accept remains in the array.
- Back-pressure: while `i_rsp_ready` = 0 in RESP, the outputs are frozen for any number of cycles.
- The address subtraction is done at `ADDR_WIDTH` with wrap-around. The range check is an unsigned compare of the difference against `DEPTH*4`, so addresses below `BASE_ADDR` wrap to large values and flag an error.

## Structure

- Shared package `ram_pkg`:
  - state enum `ram_rsp_state_e` {IDLE, WAIT, RESP};
  - `RAM_BASE_ADDR_DEF` and `RAM_DEPTH_DEF` constants.
- Sub-module `ram_sp_array`:
  - single-port synchronous array, `DEPTH` × `DATA_WIDTH`;
  - one edge does read-old and write;
  - no reset;
  - the only part that maps to a technology SRAM.
- `ram_rsp` contains the FSM, wait counter, range check and response register.

## Test plan

- Write then read, `LATENCY` = 2: wr `0x8000_0010` ← 0xDEAD_BEEF, then rd `0x8000_0010` → rsp data 0xDEAD_BEEF, err 0, `o_rsp_valid` exactly 2 cycles after each accept.
- Read-before-write: word holds 0x1111_1111; one request with `rd_en = wr_en = 1` and data 0x2222_2222 → rsp 0x1111_1111; a following read → 0x2222_2222.
- Out of range: wr `0x7FFF_FFFC` and wr `BASE + DEPTH*4` → err 1, data 0; a read of `BASE` is unchanged.
- Back-pressure: hold `i_rsp_ready` = 0 for 5 cycles in RESP → outputs stable, `o_req_ready` = 0, a request presented meanwhile is not accepted.
- `LATENCY` = 1 build: back-to-back reads to 0x8000_0000 and 0x8000_0004 with `i_rsp_ready` = 1 → accepts every 2 cycles, rsp valid 1 cycle after each accept.
- Reset in WAIT after a write accept → `o_rsp_valid` = 0, `o_req_ready` = 1 immediately; a read of the same address after reset returns the written data.
